// File: rtl/inc16_unit.sv
// inc16_unit: registered 16-bit incrementer with carry-out.
// A ripple chain of 16 half adders with the LSB carry-in tied high computes
// in_data + 1. The sum and carry are captured one cycle later when in_valid is set.
module inc16_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic [15:0] out_data,
    output logic        out_carry,
    output logic        out_valid
);

    logic [15:0] s;
    logic [16:0] c;

    // Half-adder ripple chain: each stage adds the incoming carry to one operand bit.
    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = 1'b1;
        for (int unsigned i = 0; i < 16; i++) begin
            s[i]     = in_data[i] ^ c[i];
            c[i + 1] = in_data[i] & c[i];
        end
    end

    // Output register: capture on valid input; otherwise hold data/carry and drop valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_carry <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data  <= s;
                out_carry <= c[16];
            end
        end
    end

endmodule

// File: tb/tb_inc16_unit.sv
// tb_inc16_unit: self-checking bench for inc16_unit against an arithmetic in+1 model.
module tb_inc16_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic [15:0] out_data;
    logic        out_carry;
    logic        out_valid;

    int checks   = 0;
    int failures = 0;

    // Reference model state: what the output register should hold right now.
    logic [15:0] exp_data;
    logic        exp_carry;
    logic        exp_valid;

    inc16_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one input and advance the model to what the next edge will produce.
    task automatic drive(input logic [15:0] d, input logic v);
        logic [16:0] sum;
        in_data  = d;
        in_valid = v;
        if (v) begin
            sum       = {1'b0, d} + 17'd1;
            exp_data  = sum[15:0];
            exp_carry = sum[16];
        end
        exp_valid = v;
    endtask

    task automatic model_reset();
        exp_data  = 16'h0000;
        exp_carry = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Values held right after reset release, before any capture.
        checks++;
        if (out_data !== 16'h0000 || out_carry !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_initial: got data=%h carry=%b valid=%b want 0000/0/0",
                     out_data, out_carry, out_valid);
        end
        drive(16'hFFFF, 1'b1);
        advance();
        checks++;
        if (out_data !== 16'h0000 || out_carry !== 1'b1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_precond: got data=%h carry=%b valid=%b want 0000/1/1",
                     out_data, out_carry, out_valid);
        end
        drive(16'h1234, 1'b1);
        advance();
        // Assert reset mid-cycle; outputs must clear with no clock edge.
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (out_data !== 16'h0000 || out_carry !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: got data=%h carry=%b valid=%b want 0000/0/0",
                     out_data, out_carry, out_valid);
        end
        // Clock edges while reset is held must not capture.
        advance();
        checks++;
        if (out_data !== 16'h0000 || out_carry !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: got data=%h carry=%b valid=%b want 0000/0/0",
                     out_data, out_carry, out_valid);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        advance();
        checks++;
        if (out_data !== exp_data || out_carry !== exp_carry || out_valid !== exp_valid) begin
            failures++;
            $display("FAIL reset_release: got data=%h carry=%b valid=%b want %h/%b/%b",
                     out_data, out_carry, out_valid, exp_data, exp_carry, exp_valid);
        end
    endtask

    task automatic test_directed();
        logic [15:0] ins  [3] = '{16'h0000, 16'h000F, 16'hFFFF};
        logic [15:0] outs [3] = '{16'h0001, 16'h0010, 16'h0000};
        logic        cys  [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive(ins[i], 1'b1);
            advance();
            drive(16'h0000, 1'b0);
            checks++;
            if (out_data !== outs[i] || out_carry !== cys[i] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL directed_%0d: in=%h got data=%h carry=%b valid=%b want %h/%b/1",
                         i, ins[i], out_data, out_carry, out_valid, outs[i], cys[i]);
            end
            advance();
            checks++;
            if (out_valid !== 1'b0 || out_data !== outs[i]) begin
                failures++;
                $display("FAIL directed_gap_%0d: got data=%h valid=%b want %h/0",
                         i, out_data, out_valid, outs[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ins  [3] = '{16'h7FFF, 16'h8000, 16'hFFFE};
        logic [15:0] outs [3] = '{16'h8000, 16'h8001, 16'hFFFF};
        for (int i = 0; i < 3; i++) begin
            drive(ins[i], 1'b1);
            advance();
            checks++;
            if (out_data !== outs[i] || out_carry !== 1'b0 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL b2b_%0d: got data=%h carry=%b valid=%b want %h/0/1",
                         i, out_data, out_carry, out_valid, outs[i]);
            end
        end
        // Valid drops; data held at FFFF even with X on in_data.
        drive(16'hxxxx, 1'b0);
        for (int i = 0; i < 2; i++) begin
            advance();
            checks++;
            if (out_data !== 16'hFFFF || out_carry !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL hold_%0d: got data=%h carry=%b valid=%b want FFFF/0/0",
                         i, out_data, out_carry, out_valid);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (out_data !== 16'h0000 || out_carry !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_reset: got data=%h carry=%b valid=%b want 0000/0/0",
                     out_data, out_carry, out_valid);
        end
        in_data = 16'h0000;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset_midstream();
        drive(16'h00FF, 1'b1);
        advance();
        drive(16'hABCD, 1'b1);
        #4 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (out_data !== 16'h0000 || out_carry !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midstream_async: got data=%h carry=%b valid=%b want 0000/0/0",
                     out_data, out_carry, out_valid);
        end
        in_valid = 1'b0;
        #1 rst_n = 1'b1;
        advance();
        checks++;
        if (out_data !== 16'h0000 || out_carry !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midstream_nopulse: got data=%h carry=%b valid=%b want 0000/0/0",
                     out_data, out_carry, out_valid);
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic        v;
        for (int i = 0; i < 1000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            d = 16'($urandom);
            if (!v && $urandom_range(0, 1) == 1)
                d = 16'hxxxx;
            drive(d, v);
            advance();
            checks++;
            if (out_data !== exp_data || out_carry !== exp_carry || out_valid !== exp_valid) begin
                failures++;
                $display("FAIL random_%0d: got data=%h carry=%b valid=%b want %h/%b/%b",
                         i, out_data, out_carry, out_valid, exp_data, exp_carry, exp_valid);
            end
        end
    endtask

    task automatic test_sweep();
        int unsigned want;
        for (int i = 0; i < 65536; i++) begin
            drive(16'(i), 1'b1);
            advance();
            want = i + 1;
            checks++;
            if (out_data !== want[15:0] || out_carry !== want[16] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL sweep_%h: got data=%h carry=%b valid=%b want %h/%b/1",
                         i[15:0], out_data, out_carry, out_valid, want[15:0], want[16]);
            end
        end
        drive(16'h0000, 1'b0);
        advance();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_carry !== 1'b1) begin
            failures++;
            $display("FAIL sweep_end: got data=%h carry=%b valid=%b want 0000/1/0",
                     out_data, out_carry, out_valid);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        model_reset();
        #22 rst_n = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
